// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed six-digit common-anode driver with frame latching, blanking and blink
module seg7_scan_mux #(
    parameter int         REFRESH_DIV  = 4,
    parameter int         BLANK_CYCLES = 1,
    parameter int         BLINK_DIV    = 2,
    parameter logic [6:0] ZERO_PAT     = 7'b0111111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg7_points_2,
    input  logic [6:0] seg7_points_1,
    input  logic [6:0] seg7_points_0,
    input  logic [6:0] seg7_timer_1,
    input  logic [6:0] seg7_timer_0,
    input  logic [6:0] seg7_level,
    input  logic       Done,
    input  logic       blank_lz,
    output logic [6:0] seg_out,
    output logic [5:0] an_out,
    output logic       frame_tick
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [2:0]    slot;
    logic [CW-1:0] cnt;
    logic [6:0]    sh_p2, sh_p1, sh_p0, sh_t1, sh_t0, sh_lv;
    logic          done_sh, lz_sh, phase_on;
    logic [BW-1:0] blink_cnt;
    logic          frame_start, lz0, lz1, digit_on;
    logic [6:0]    pat;

    always_comb begin
        frame_start = slot == 3'd0 && cnt == '0;
        lz0 = lz_sh && sh_p2 == ZERO_PAT;
        lz1 = lz0 && sh_p1 == ZERO_PAT;
        digit_on = cnt >= BLANK && phase_on && !(slot == 3'd0 && lz0) && !(slot == 3'd1 && lz1);
        pat = slot == 3'd0 ? sh_p2 :
              slot == 3'd1 ? sh_p1 :
              slot == 3'd2 ? sh_p0 :
              slot == 3'd3 ? sh_t1 :
              slot == 3'd4 ? sh_t0 : sh_lv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= 3'd0;
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            slot <= slot == 3'd5 ? 3'd0 : slot + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadows and blink state only move at frame start so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sh_p2, sh_p1, sh_p0, sh_t1, sh_t0, sh_lv} <= '0;
            done_sh <= 1'b0;
            lz_sh <= 1'b0;
            phase_on <= 1'b1;
            blink_cnt <= '0;
        end else if (frame_start) begin
            {sh_p2, sh_p1, sh_p0} <= {seg7_points_2, seg7_points_1, seg7_points_0};
            {sh_t1, sh_t0, sh_lv} <= {seg7_timer_1, seg7_timer_0, seg7_level};
            done_sh <= Done;
            lz_sh <= blank_lz;
            if (!Done || !done_sh) begin
                phase_on <= 1'b1;
                blink_cnt <= '0;
            end else if (blink_cnt == BLINK_MAX) begin
                phase_on <= ~phase_on;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= 7'h7F;
            an_out <= 6'h3F;
            frame_tick <= 1'b0;
        end else begin
            seg_out <= digit_on ? ~pat : 7'h7F;
            an_out <= digit_on ? ~(6'b1 << slot) : 6'h3F;
            frame_tick <= frame_start;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert ($countones(~an_out) <= 1);
    end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed table plus hand-written sequences for the scan multiplexer
module tb_seg7_scan_mux;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] p2, p1, p0, t1, t0, lv;
    logic       done, lz;
    logic [6:0] seg_out;
    logic [5:0] an_out;
    logic       frame_tick;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         k = -1;

    seg7_scan_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(1), .BLINK_DIV(2), .ZERO_PAT(7'b0111111)) dut (
        .clk(clk), .rst_n(rst_n),
        .seg7_points_2(p2), .seg7_points_1(p1), .seg7_points_0(p0),
        .seg7_timer_1(t1), .seg7_timer_0(t0), .seg7_level(lv),
        .Done(done), .blank_lz(lz),
        .seg_out(seg_out), .an_out(an_out), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [5:0] an;
        logic [6:0] seg;
        logic       tick;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", name, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic go_to(input int pos);
        bit hit = 0;
        for (int i = 0; i < 24 && !hit; i++) begin
            step();
            hit = (k % 24) == pos;
        end
        if (!hit) chk("go_to_timeout", 0, 1);
    endtask

    task automatic chk_digit(input string name, input logic [5:0] an, input logic [6:0] seg);
        chk({name, "_an"}, int'(an_out), int'(an));
        chk({name, "_seg"}, int'(seg_out), int'(seg));
    endtask

    task automatic set_static();
        {p2, p1, p0} = {7'h06, 7'h5B, 7'h4F};
        {t1, t0, lv} = {7'h66, 7'h6D, 7'h7D};
    endtask

    initial begin
        tbl[0]  = '{0, 6'h3F, 7'h7F, 1'b1};
        tbl[1]  = '{1, 6'h3E, 7'h79, 1'b0};
        tbl[2]  = '{3, 6'h3E, 7'h79, 1'b0};
        tbl[3]  = '{4, 6'h3F, 7'h7F, 1'b0};
        tbl[4]  = '{5, 6'h3D, 7'h24, 1'b0};
        tbl[5]  = '{7, 6'h3D, 7'h24, 1'b0};
        tbl[6]  = '{8, 6'h3F, 7'h7F, 1'b0};
        tbl[7]  = '{9, 6'h3B, 7'h30, 1'b0};
        tbl[8]  = '{13, 6'h37, 7'h19, 1'b0};
        tbl[9]  = '{17, 6'h2F, 7'h12, 1'b0};
        tbl[10] = '{21, 6'h1F, 7'h02, 1'b0};
        tbl[11] = '{23, 6'h1F, 7'h02, 1'b0};
        tbl[12] = '{24, 6'h3F, 7'h7F, 1'b1};
        tbl[13] = '{25, 6'h3E, 7'h79, 1'b0};
        set_static();
        done = 1'b0;
        lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_digit("reset_hold", 6'h3F, 7'h7F);
        chk("reset_hold_tick", int'(frame_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        k = -1;
        foreach (tbl[i]) begin
            while (k < tbl[i].at) step();
            chk_digit($sformatf("scan_p%0d", tbl[i].at), tbl[i].an, tbl[i].seg);
            chk($sformatf("scan_tick_p%0d", tbl[i].at), int'(frame_tick), int'(tbl[i].tick));
        end
        go_to(6);
        chk_digit("pre_async", 6'h3D, 7'h24);
        #2;
        rst_n = 1'b0;
        #1;
        chk_digit("async_reset", 6'h3F, 7'h7F);
        chk("async_reset_tick", int'(frame_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        k = -1;
        step();
        chk("restart_tick", int'(frame_tick), 1);
        step();
        chk_digit("restart_slot0", 6'h3E, 7'h79);
        chk("restart_tick_off", int'(frame_tick), 0);
        go_to(10);
        t0 = 7'h07;
        go_to(17);
        chk_digit("tear_p17", 6'h2F, 7'h12);
        go_to(19);
        chk_digit("tear_p19", 6'h2F, 7'h12);
        go_to(17);
        chk_digit("tear_next", 6'h2F, 7'h78);
        {p2, p1, p0} = {3{7'h3F}};
        lz = 1'b1;
        go_to(0);
        go_to(1);
        chk_digit("lz_slot0", 6'h3F, 7'h7F);
        go_to(5);
        chk_digit("lz_slot1", 6'h3F, 7'h7F);
        go_to(9);
        chk_digit("lz_slot2", 6'h3B, 7'h40);
        go_to(13);
        chk_digit("lz_slot3", 6'h37, 7'h19);
        p1 = 7'h5B;
        go_to(0);
        go_to(1);
        chk_digit("lz_part_slot0", 6'h3F, 7'h7F);
        go_to(5);
        chk_digit("lz_part_slot1", 6'h3D, 7'h24);
        p1 = 7'h3F;
        lz = 1'b0;
        go_to(0);
        go_to(1);
        chk_digit("nolz_slot0", 6'h3E, 7'h40);
        go_to(5);
        chk_digit("nolz_slot1", 6'h3D, 7'h40);
        set_static();
        done = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            go_to(0);
            chk($sformatf("blink_f%0d_tick", f), int'(frame_tick), 1);
            go_to(1);
            if (f <= 2 || f >= 5) chk_digit($sformatf("blink_f%0d_p1", f), 6'h3E, 7'h79);
            else chk_digit($sformatf("blink_f%0d_p1", f), 6'h3F, 7'h7F);
            go_to(13);
            if (f <= 2 || f >= 5) chk_digit($sformatf("blink_f%0d_p13", f), 6'h37, 7'h19);
            else chk_digit($sformatf("blink_f%0d_p13", f), 6'h3F, 7'h7F);
        end
        go_to(0);
        chk("blink_f7_tick", int'(frame_tick), 1);
        go_to(1);
        chk_digit("blink_f7_p1", 6'h3F, 7'h7F);
        done = 1'b0;
        go_to(13);
        chk_digit("blink_f7_p13", 6'h3F, 7'h7F);
        go_to(0);
        go_to(1);
        chk_digit("blink_f8_p1", 6'h3E, 7'h79);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
